// File: rtl/fetch_group_buffer_if.sv
// Fetch-side and decode-side signal bundle of the fetch group buffer.
// The buffer connects through the slave modport; the fetch/decode environment connects through master.
interface fetch_group_buffer_if #(
  parameter int size = 32
);
  logic            parallel_mode;
  logic            fetch_valid_0;
  logic            fetch_valid_1;
  logic            fetch_valid_2;
  logic [size-1:0] instruction_i_0;
  logic [size-1:0] instruction_i_1;
  logic [size-1:0] instruction_i_2;
  logic [size-1:0] pc_i_0;
  logic [size-1:0] pc_i_1;
  logic [size-1:0] pc_i_2;
  logic            misprediction;
  logic            decode_ready;
  logic [size-1:0] instruction_o_0;
  logic [size-1:0] instruction_o_1;
  logic [size-1:0] instruction_o_2;
  logic [size-1:0] pc_o_0;
  logic [size-1:0] pc_o_1;
  logic [size-1:0] pc_o_2;
  logic            valid_o_0;
  logic            valid_o_1;
  logic            valid_o_2;
  logic            buble;
  logic            overflow_err;

  modport master (
    output parallel_mode, fetch_valid_0, fetch_valid_1, fetch_valid_2,
    output instruction_i_0, instruction_i_1, instruction_i_2,
    output pc_i_0, pc_i_1, pc_i_2, misprediction, decode_ready,
    input  instruction_o_0, instruction_o_1, instruction_o_2,
    input  pc_o_0, pc_o_1, pc_o_2, valid_o_0, valid_o_1, valid_o_2,
    input  buble, overflow_err
  );

  modport slave (
    input  parallel_mode, fetch_valid_0, fetch_valid_1, fetch_valid_2,
    input  instruction_i_0, instruction_i_1, instruction_i_2,
    input  pc_i_0, pc_i_1, pc_i_2, misprediction, decode_ready,
    output instruction_o_0, instruction_o_1, instruction_o_2,
    output pc_o_0, pc_o_1, pc_o_2, valid_o_0, valid_o_1, valid_o_2,
    output buble, overflow_err
  );
endinterface

// File: rtl/fetch_group_buffer.sv
// Circular instruction queue between fetch and superscalar decode: up to three
// {instruction, pc} entries in and out per cycle, stall request, flush and sticky overflow flag.
module fetch_group_buffer #(
  parameter int size  = 32,
  parameter int DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  fetch_group_buffer_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [size-1:0] instr_mem_q [DEPTH];
  logic [size-1:0] pc_mem_q    [DEPTH];

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;

  logic [CW-1:0] g_s, enq_s, free_s, pop_s;
  logic          fits_s;
  logic [2:0]    wr_en_s;
  logic [AW-1:0] wr_idx_s [3];
  logic [AW-1:0] rd_idx_s [3];
  logic [size-1:0] wr_instr_s [3];
  logic [size-1:0] wr_pc_s    [3];

  assign wr_instr_s[0] = bus.instruction_i_0;
  assign wr_instr_s[1] = bus.instruction_i_1;
  assign wr_instr_s[2] = bus.instruction_i_2;
  assign wr_pc_s[0]    = bus.pc_i_0;
  assign wr_pc_s[1]    = bus.pc_i_1;
  assign wr_pc_s[2]    = bus.pc_i_2;

  // Group size, enqueue length (contiguous lanes from lane 0) and dequeue length.
  always_comb begin
    g_s   = bus.parallel_mode ? CW'(3) : CW'(1);
    enq_s = CW'(0);
    if (bus.parallel_mode) begin
      if (bus.fetch_valid_0) begin
        if (bus.fetch_valid_1) begin
          enq_s = bus.fetch_valid_2 ? CW'(3) : CW'(2);
        end else begin
          enq_s = CW'(1);
        end
      end else begin
        enq_s = CW'(0);
      end
    end else begin
      enq_s = bus.fetch_valid_0 ? CW'(1) : CW'(0);
    end
    free_s = CW'(DEPTH) - count_q;
    fits_s = (enq_s <= free_s);
    if (bus.decode_ready) begin
      pop_s = (count_q < g_s) ? count_q : g_s;
    end else begin
      pop_s = CW'(0);
    end
  end

  // Next pointer/count state; a flush overrides any enqueue or dequeue in the same cycle.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    err_d   = err_q;
    wr_en_s = 3'b000;
    for (int k = 0; k < 3; k++) begin
      wr_idx_s[k] = tail_q + AW'(k);
    end
    if (bus.misprediction) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d = head_q + AW'(pop_s);
      if (fits_s) begin
        tail_d  = tail_q + AW'(enq_s);
        count_d = count_q + enq_s - pop_s;
        for (int k = 0; k < 3; k++) begin
          wr_en_s[k] = (enq_s > CW'(k));
        end
      end else begin
        count_d = count_q - pop_s;
        err_d   = 1'b1;
      end
    end
  end

  // Pointer, occupancy and error state.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Entry storage is deliberately not reset; valid_o masks stale contents.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (wr_en_s[k]) begin
        instr_mem_q[wr_idx_s[k]] <= wr_instr_s[k];
        pc_mem_q[wr_idx_s[k]]    <= wr_pc_s[k];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      rd_idx_s[k] = head_q + AW'(k);
    end
  end

  assign bus.instruction_o_0 = instr_mem_q[rd_idx_s[0]];
  assign bus.instruction_o_1 = instr_mem_q[rd_idx_s[1]];
  assign bus.instruction_o_2 = instr_mem_q[rd_idx_s[2]];
  assign bus.pc_o_0          = pc_mem_q[rd_idx_s[0]];
  assign bus.pc_o_1          = pc_mem_q[rd_idx_s[1]];
  assign bus.pc_o_2          = pc_mem_q[rd_idx_s[2]];

  assign bus.valid_o_0 = (count_q > CW'(0));
  assign bus.valid_o_1 = bus.parallel_mode && (count_q > CW'(1));
  assign bus.valid_o_2 = bus.parallel_mode && (count_q > CW'(2));

  // Stall leaves room for one more group already in flight.
  assign bus.buble        = (free_s < (g_s << 1));
  assign bus.overflow_err = err_q;
endmodule
